// File: rtl/convclk2x_sched.sv
// convclk2x_sched: round-robin packet scheduler onto the clk2x conversion slot stream.
// Optional phase checker compiled in with CONVSCHED_PHASECHK_EN.
module convclk2x_sched #(
    parameter int WIDTH  = 8,
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int MAXGAP = 15
) (
    input  logic                  clk2x,
    input  logic                  rst2x,
    input  logic                  phase,
    input  logic [NREQ-1:0]       req_vld,
    input  logic [NREQ-1:0]       req_eop,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_rdy,
    output logic                  out_vld,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  out_abort,
    output logic [IDW-1:0]        out_id,
    output logic [WIDTH-1:0]      out_data,
    output logic                  busy,
    output logic                  phase_err
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   ptr, ptr_nxt;
    logic [IDW-1:0]   g, g_nxt;
    logic [IDW-1:0]   winner, sel;
    logic [7:0]       gap, gap_nxt;
    logic             found, any_vld, acc, tmo, eop_sel;
    logic [WIDTH-1:0] data_sel;

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
        return (v == IDW'(NREQ-1)) ? '0 : v + 1'b1;
    endfunction

    // Two passes give the wrap-around search starting at ptr.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_vld[i] && IDW'(i) >= ptr) begin
                winner = IDW'(i);
                found  = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_vld[i]) begin
                winner = IDW'(i);
                found  = 1'b1;
            end
        end
    end

    assign any_vld = |req_vld;
    assign sel     = (state == LOCK) ? g : winner;

    always_comb begin
        req_rdy  = '0;
        data_sel = '0;
        eop_sel  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_rdy[i] = phase &
                (((state == IDLE) & any_vld & (winner == IDW'(i))) |
                 ((state == LOCK) & (g == IDW'(i))));
            if (sel == IDW'(i)) begin
                data_sel = req_data[i*WIDTH +: WIDTH];
                eop_sel  = req_eop[i];
            end
        end
    end

    assign acc = |(req_vld & req_rdy);
    assign tmo = (state == LOCK) & phase & ~acc & (gap == 8'(MAXGAP-1));

    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        ptr_nxt   = ptr;
        gap_nxt   = gap;
        unique case (state)
            IDLE: begin
                if (acc) begin
                    if (eop_sel) begin
                        ptr_nxt = wrap_inc(winner);
                    end else begin
                        state_nxt = LOCK;
                        g_nxt     = winner;
                        gap_nxt   = '0;
                    end
                end
            end
            LOCK: begin
                if (acc) begin
                    gap_nxt = '0;
                    if (eop_sel) begin
                        state_nxt = IDLE;
                        ptr_nxt   = wrap_inc(g);
                    end
                end else if (tmo) begin
                    state_nxt = IDLE;
                    ptr_nxt   = wrap_inc(g);
                    gap_nxt   = '0;
                end else if (phase) begin
                    gap_nxt = gap + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk2x) begin
        if (rst2x) begin
            state     <= IDLE;
            g         <= '0;
            ptr       <= '0;
            gap       <= '0;
            busy      <= 1'b0;
            out_vld   <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_abort <= 1'b0;
            out_id    <= '0;
            out_data  <= '0;
        end else begin
            state     <= state_nxt;
            g         <= g_nxt;
            ptr       <= ptr_nxt;
            gap       <= gap_nxt;
            busy      <= (state_nxt == LOCK);
            out_vld   <= acc | tmo;
            out_sop   <= acc & (state == IDLE);
            out_eop   <= (acc & eop_sel) | tmo;
            out_abort <= tmo;
            if (acc) begin
                out_id   <= sel;
                out_data <= data_sel;
            end else if (tmo) begin
                out_id   <= g;
                out_data <= '0;
            end
        end
    end

`ifdef CONVSCHED_PHASECHK_EN
    logic       phase_q;
    logic [1:0] age;

    // age counts cycles since reset release, saturating at 2.
    always_ff @(posedge clk2x) begin
        if (rst2x) begin
            phase_q   <= 1'b0;
            age       <= 2'd0;
            phase_err <= 1'b0;
        end else begin
            phase_q <= phase;
            if (age != 2'd2) begin
                age <= age + 2'd1;
            end
            if ((age == 2'd2 && phase == phase_q) ||
                (age == 2'd1 && phase_q && phase)) begin
                phase_err <= 1'b1;
            end
        end
    end
`else
    assign phase_err = 1'b0;
`endif

endmodule

// File: tb/tb_convclk2x_sched.sv
// tb_convclk2x_sched: directed checks of the clk2x round-robin scheduler.
// Expected values are hand-derived per slot.
module tb_convclk2x_sched;

    logic        clk2x = 1'b0;
    logic        rst2x;
    logic        phase;
    logic [3:0]  req_vld;
    logic [3:0]  req_eop;
    logic [31:0] req_data;
    logic [3:0]  req_rdy;
    logic        out_vld, out_sop, out_eop, out_abort;
    logic [1:0]  out_id;
    logic [7:0]  out_data;
    logic        busy, phase_err;

    int n_chk = 0;
    int n_err = 0;
    int wc[4];
    bit ph_auto;

    convclk2x_sched #(
        .WIDTH(8), .NREQ(4), .IDW(2), .MAXGAP(15)
    ) dut (
        .clk2x    (clk2x),
        .rst2x    (rst2x),
        .phase    (phase),
        .req_vld  (req_vld),
        .req_eop  (req_eop),
        .req_data (req_data),
        .req_rdy  (req_rdy),
        .out_vld  (out_vld),
        .out_sop  (out_sop),
        .out_eop  (out_eop),
        .out_abort(out_abort),
        .out_id   (out_id),
        .out_data (out_data),
        .busy     (busy),
        .phase_err(phase_err)
    );

    always #5 clk2x = ~clk2x;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk2x);
        #1;
        if (ph_auto) phase = ~phase;
    endtask

    task automatic set_in(input logic [3:0] v, input logic [3:0] e);
        req_vld = v;
        req_eop = e;
        for (int i = 0; i < 4; i++)
            req_data[i*8 +: 8] = {4'(i), 4'(wc[i])};
    endtask

    task automatic do_slot(input string tag,
                           input logic [3:0] v, input logic [3:0] e,
                           input logic [3:0] rdy, input logic ov,
                           input logic [1:0] oid, input logic osop,
                           input logic oeop, input logic oab,
                           input logic [7:0] od, input logic ob);
        if (!phase) begin
            set_in(v, e);
            #1;
            check({tag, "_nsrdy"}, req_rdy, 0);
            tick();
            check({tag, "_nsvld"}, out_vld, 0);
        end
        set_in(v, e);
        #1;
        check({tag, "_rdy"}, req_rdy, rdy);
        tick();
        for (int i = 0; i < 4; i++)
            if (v[i] && rdy[i]) wc[i]++;
        check({tag, "_vld"}, out_vld, ov);
        if (ov) begin
            check({tag, "_id"}, out_id, oid);
            check({tag, "_sop"}, out_sop, osop);
            check({tag, "_eop"}, out_eop, oeop);
            check({tag, "_abort"}, out_abort, oab);
            check({tag, "_data"}, out_data, od);
        end
        check({tag, "_busy"}, busy, ob);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) wc[i] = 0;
        ph_auto  = 1'b1;
        rst2x    = 1'b1;
        phase    = 1'b0;
        set_in(4'b0000, 4'b0000);

        // reset with phase toggling, no requests
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_rdy", req_rdy, 0);
        end
        check("rst_vld", out_vld, 0);
        check("rst_sop", out_sop, 0);
        check("rst_eop", out_eop, 0);
        check("rst_abort", out_abort, 0);
        check("rst_id", out_id, 0);
        check("rst_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_perr", phase_err, 0);
        rst2x = 1'b0;
        tick();
        tick();
        check("rel_vld", out_vld, 0);
        check("rel_busy", busy, 0);

        // two 3-word packets from req0 then req2; req0 ignored while locked
        do_slot("t2s1", 4'b0101, 4'b0000, 4'b0001, 1, 0, 1, 0, 0, 8'h00, 1);
        do_slot("t2s2", 4'b0101, 4'b0000, 4'b0001, 1, 0, 0, 0, 0, 8'h01, 1);
        do_slot("t2s3", 4'b0101, 4'b0001, 4'b0001, 1, 0, 0, 1, 0, 8'h02, 0);
        do_slot("t2s4", 4'b0101, 4'b0000, 4'b0100, 1, 2, 1, 0, 0, 8'h20, 1);
        do_slot("t2s5", 4'b0101, 4'b0000, 4'b0100, 1, 2, 0, 0, 0, 8'h21, 1);
        do_slot("t2s6", 4'b0101, 4'b0100, 4'b0100, 1, 2, 0, 1, 0, 8'h22, 0);
        do_slot("t2s7", 4'b0001, 4'b0001, 4'b0001, 1, 0, 1, 1, 0, 8'h03, 0);

        // single-word packets from all requesters, pointer now at 1
        do_slot("t3a", 4'b1111, 4'b1111, 4'b0010, 1, 1, 1, 1, 0, 8'h10, 0);
        do_slot("t3b", 4'b1111, 4'b1111, 4'b0100, 1, 2, 1, 1, 0, 8'h23, 0);
        do_slot("t3c", 4'b1111, 4'b1111, 4'b1000, 1, 3, 1, 1, 0, 8'h30, 0);
        do_slot("t3d", 4'b1111, 4'b1111, 4'b0001, 1, 0, 1, 1, 0, 8'h04, 0);
        do_slot("t3e", 4'b1111, 4'b1111, 4'b0010, 1, 1, 1, 1, 0, 8'h11, 0);

        // req1 starts a packet then stalls for 15 slots
        do_slot("t4go", 4'b0010, 4'b0000, 4'b0010, 1, 1, 1, 0, 0, 8'h12, 1);
        for (int k = 0; k < 14; k++)
            do_slot("t4gap", 4'b0000, 4'b0000, 4'b0010, 0, 0, 0, 0, 0, 8'h00, 1);
        do_slot("t4abort", 4'b0000, 4'b0000, 4'b0010, 1, 1, 0, 1, 1, 8'h00, 0);
        do_slot("t4next", 4'b0110, 4'b0110, 4'b0100, 1, 2, 1, 1, 0, 8'h24, 0);

        // reset mid-packet, then lowest pending index wins
        do_slot("t5a", 4'b1000, 4'b0000, 4'b1000, 1, 3, 1, 0, 0, 8'h31, 1);
        set_in(4'b0000, 4'b0000);
        rst2x = 1'b1;
        tick();
        check("t5r_vld", out_vld, 0);
        check("t5r_sop", out_sop, 0);
        check("t5r_eop", out_eop, 0);
        check("t5r_abort", out_abort, 0);
        check("t5r_id", out_id, 0);
        check("t5r_data", out_data, 0);
        check("t5r_busy", busy, 0);
        rst2x = 1'b0;
        do_slot("t5b", 4'b1010, 4'b1010, 4'b0010, 1, 1, 1, 1, 0, 8'h13, 0);

        // phase held high for two cycles
        set_in(4'b0000, 4'b0000);
        if (!phase) tick();
        ph_auto = 1'b0;
        tick();
        tick();
`ifdef CONVSCHED_PHASECHK_EN
        check("t6_perr", phase_err, 1);
`else
        check("t6_perr", phase_err, 0);
`endif
        ph_auto = 1'b1;
        tick();
        tick();
        tick();
`ifdef CONVSCHED_PHASECHK_EN
        check("t6_sticky", phase_err, 1);
`else
        check("t6_sticky", phase_err, 0);
`endif
        rst2x = 1'b1;
        tick();
        check("t6_rst", phase_err, 0);
        rst2x = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("t6_clean", phase_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
